// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART scheduler types: FSM state encoding, baud select codes, byte width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } tx_state_e;

  localparam int UART_DW = 8;

  localparam logic [3:0] BAUD_9600   = 4'd0;
  localparam logic [3:0] BAUD_19200  = 4'd1;
  localparam logic [3:0] BAUD_38400  = 4'd2;
  localparam logic [3:0] BAUD_57600  = 4'd3;
  localparam logic [3:0] BAUD_115200 = 4'd4;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rtl/uart_tx_sched_rr_arbiter.sv - combinational round-robin pick: first request at or above ptr_i, with wrap.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    int best;
    int best_dist;
    best      = 0;
    best_dist = N;
    gnt_o     = '0;
    any_o     = 1'b0;
    // Distance from the pointer in wrap order; the smallest distance wins.
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && (((i + N - int'(ptr_i)) % N) < best_dist)) begin
        best_dist = (i + N - int'(ptr_i)) % N;
        best      = i;
        any_o     = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (any_o && (i == best)) gnt_o[i] = 1'b1;
    end
    idx_o = IDX_W'(best);
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one UART byte transmitter among NUM_REQ requesters.
// Optional WAIT timeout abort enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [3:0]             cfg_baud,
  output logic [3:0]             tx_baud,
  output logic [UART_DW-1:0]     tx_data,
  output logic                   tx_start,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [IDX_W-1:0]       grant_id,
  output logic                   timeout_err
);

  tx_state_e            state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gid_q, gid_d;
  logic [UART_DW-1:0]   data_q, data_d;
  logic [3:0]           baud_q, baud_d;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [IDX_W-1:0]     ptr_after;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic [15:0]          cnt_q, cnt_d;
`else
  logic                 unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign ptr_after = (gid_q == IDX_W'(NUM_REQ - 1)) ? '0 : gid_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    data_d      = data_q;
    baud_d      = baud_q;
    req_ready   = '0;
    tx_start    = 1'b0;
    busy        = 1'b0;
    timeout_err = 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = cfg_baud;
        if (arb_any) begin
          // Strobe is masked so nothing leaks out while reset is held.
          req_ready = arb_gnt & {NUM_REQ{rst}};
          gid_d     = arb_idx;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) data_d = req_data[i*UART_DW +: UART_DW];
          end
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start = 1'b1;
        busy     = 1'b1;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        cnt_d    = '0;
`endif
        state_d  = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (tx_done) begin
          ptr_d   = ptr_after;
          state_d = IDLE;
        end
`ifdef UART_TX_SCHED_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
          timeout_err = 1'b1;
          ptr_d       = ptr_after;
          state_d     = IDLE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
      baud_q  <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      baud_q  <= baud_d;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign tx_data  = data_q;
  assign grant_id = gid_q;
  assign tx_baud  = baud_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched against a round-robin reference model.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  cfg_baud;
  logic [3:0]  tx_baud;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .NUM_REQ     (4),
    .IDX_W       (2),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .cfg_baud    (cfg_baud),
    .tx_baud     (tx_baud),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      int s;
      s = (ptr + k) % 4;
      if (v[s[1:0]]) return s;
    end
    return -1;
  endfunction

  // Caller sits just after a negedge in IDLE; returns just after the first IDLE negedge following tx_done.
  task automatic run_grant(input logic [3:0] v, input logic [31:0] d, input int dly,
                           input logic [3:0] pre_v, input bit spur_launch);
    int w;
    logic [31:0] dd;
    logic [7:0] exp_d;
    w = pick(v, model_ptr);
    dd = d;
    exp_d = dd[w*8 +: 8];
    req_valid = v;
    req_data  = d;
    #1;
    check("grant_ready", req_ready, 32'(4'b1 << w));
    check("grant_busy", busy, 0);
    @(negedge clk);
    req_valid = '0;
    if (spur_launch) tx_done = 1'b1;
    #1;
    check("launch_start", tx_start, 1);
    check("launch_data", tx_data, exp_d);
    check("launch_gid", grant_id, w);
    check("launch_busy", busy, 1);
    check("launch_ready", req_ready, 0);
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    check("wait_start", tx_start, 0);
    check("wait_busy", busy, 1);
    repeat (dly) @(negedge clk);
    tx_done   = 1'b1;
    req_valid = pre_v;
    #1;
    check("done_ready", req_ready, 0);
    check("done_busy", busy, 1);
    check("done_data_held", tx_data, exp_d);
    model_ptr = (w + 1) % 4;
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    check("idle_busy", busy, 0);
    check("idle_start", tx_start, 0);
  endtask

  initial begin
    logic [3:0] masks [0:20];
    int w;
    int bad;

    rst       = 1'b0;
    req_valid = 4'hF;
    req_data  = 32'hDEADBEEF;
    cfg_baud  = 4'd7;
    tx_done   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_start", tx_start, 0);
    check("rst_baud", tx_baud, 0);
    check("rst_data", tx_data, 0);
    check("rst_gid", grant_id, 0);
    check("rst_timeout", timeout_err, 0);
    @(negedge clk);
    req_valid = '0;
    cfg_baud  = 4'd0;
    rst       = 1'b1;

    // Full contention: grants rotate 0,1,2,3,0.
    for (int i = 0; i < 5; i++) run_grant(4'hF, 32'h43322110, 19, 4'h0, 1'b0);

    // Single request with a slow serializer.
    run_grant(4'b0010, 32'h0000A500, 99, 4'h0, 1'b0);

    // Fairness after wrap from pointer 3.
    run_grant(4'b0100, $urandom, 2, 4'h0, 1'b1);
    run_grant(4'b1001, $urandom, 1, 4'b1001, 1'b0);
    run_grant(4'b1001, $urandom, 1, 4'h0, 1'b0);

    // Spurious done in IDLE.
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    check("spur_busy", busy, 0);
    check("spur_start", tx_start, 0);
    @(negedge clk);
    #1;
    check("spur_busy2", busy, 0);
    run_grant(4'hF, $urandom, 0, 4'h0, 1'b0);

    // Baud latch only in IDLE.
    cfg_baud = 4'd4;
    @(negedge clk);
    #1;
    check("baud_idle", tx_baud, 4);
    w = pick(4'b0001, model_ptr);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    cfg_baud  = 4'd1;
    #1;
    check("baud_launch", tx_baud, 4);
    check("baud_gid", grant_id, w);
    repeat (4) @(negedge clk);
    #1;
    check("baud_wait", tx_baud, 4);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    model_ptr = (w + 1) % 4;
    #1;
    check("baud_ret_busy", busy, 0);
    check("baud_ret_hold", tx_baud, 4);
    @(negedge clk);
    #1;
    check("baud_update", tx_baud, 1);

    // Reset mid-frame.
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    check("mid_busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_start", tx_start, 0);
    check("mid_rst_gid", grant_id, 0);
    @(negedge clk);
    rst = 1'b1;
    model_ptr = 0;
    run_grant(4'b1001, $urandom, 1, 4'h0, 1'b0);
    run_grant(4'b0100, $urandom, 1, 4'h0, 1'b0);

    // Randomized traffic; next mask is presented alongside tx_done.
    for (int i = 0; i < 20; i++) masks[i] = 4'($urandom_range(1, 15));
    masks[20] = 4'h0;
    for (int i = 0; i < 20; i++) begin
      run_grant(masks[i], $urandom, $urandom_range(0, 6), masks[i+1], (i % 5) == 0);
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    w = pick(4'b0010, model_ptr);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    #1;
    check("to_start", tx_start, 1);
    bad = 0;
    for (int k = 1; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (timeout_err !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("to_early", bad, 0);
    @(negedge clk);
    #1;
    check("to_pulse", timeout_err, 1);
    @(negedge clk);
    #1;
    check("to_pulse_end", timeout_err, 0);
    check("to_idle_busy", busy, 0);
    model_ptr = (w + 1) % 4;
    run_grant(4'hF, $urandom, 3, 4'h0, 1'b0);
`else
    w = pick(4'b0010, model_ptr);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      #1;
      if (timeout_err !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("no_to_hold", bad, 0);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    model_ptr = (w + 1) % 4;
    #1;
    check("no_to_release", busy, 0);
    run_grant(4'hF, $urandom, 3, 4'h0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
